// File: rtl/mod13_sched.sv
// Two-requester interval scheduler timed by a shared mod-13 tick counter.
// Define MOD13_SCHED_RR_EN for round-robin arbitration (default: req[0] wins).
module mod13_sched (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [3:0] len0,
  input  logic [3:0] len1,
  input  logic       tick,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic       busy,
  output logic [3:0] qo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] lm1_q, lm1_d;
  logic       win_q, win_d;
  logic       pick;

`ifdef MOD13_SCHED_RR_EN
  logic       last_q, last_d;
`endif

  // Terminal count: lengths 0 and 13..15 all mean a full 13-tick lap.
  function automatic logic [3:0] eff_m1(input logic [3:0] len);
    if (len == 4'd0 || len > 4'd12) eff_m1 = 4'd12;
    else eff_m1 = len - 4'd1;
  endfunction

`ifdef MOD13_SCHED_RR_EN
  always_comb begin
    if (req[0] && req[1]) pick = ~last_q;
    else pick = ~req[0];
  end
`else
  always_comb pick = ~req[0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      lm1_q   <= 4'd0;
      win_q   <= 1'b0;
`ifdef MOD13_SCHED_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lm1_q   <= lm1_d;
      win_q   <= win_d;
`ifdef MOD13_SCHED_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lm1_d   = lm1_q;
    win_d   = win_q;
`ifdef MOD13_SCHED_RR_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_RUN;
          cnt_d   = 4'd0;
          win_d   = pick;
          lm1_d   = pick ? eff_m1(len1) : eff_m1(len0);
`ifdef MOD13_SCHED_RR_EN
          last_d  = pick;
`endif
        end
      end
      S_RUN: begin
        // Abandon outranks completion on the same edge.
        if (!req[win_q]) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (tick) begin
          if (cnt_q == lm1_q) begin
            state_d = S_DONE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    logic [1:0] wsel;
    wsel = win_q ? 2'b10 : 2'b01;
    gnt  = (state_q == S_RUN) ? wsel : 2'b00;
    done = (state_q == S_DONE) ? wsel : 2'b00;
    busy = (state_q != S_IDLE);
    qo   = cnt_q;
  end

endmodule

// File: tb/tb_mod13_sched.sv
// Directed bench for mod13_sched; inputs driven and outputs sampled
// on the falling edge.
module tb_mod13_sched;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic [3:0] len0;
  logic [3:0] len1;
  logic       tick;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       busy;
  logic [3:0] qo;

  int n_chk;
  int n_pass;

  mod13_sched dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .len0 (len0),
    .len1 (len1),
    .tick (tick),
    .gnt  (gnt),
    .done (done),
    .busy (busy),
    .qo   (qo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h exp %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] exp_g [3];
    logic [3:0] ecnt;
    logic       t;
    logic       seen;
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    req    = 2'b00;
    len0   = 4'd0;
    len1   = 4'd0;
    tick   = 1'b0;

    #1;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_qo", qo, 4'd0);

    // Short interval on requester 0
    cyc();
    rst_n = 1'b1;
    req   = 2'b01;
    len0  = 4'd3;
    tick  = 1'b1;
    cyc();
    chk("t1_gnt", gnt, 2'b01);
    chk("t1_busy", busy, 1'b1);
    chk("t1_qo0", qo, 4'd0);
    cyc();
    chk("t1_qo1", qo, 4'd1);
    cyc();
    chk("t1_qo2", qo, 4'd2);
    cyc();
    chk("t1_done", done, 2'b01);
    chk("t1_gnt0", gnt, 2'b00);
    chk("t1_qow", qo, 4'd0);
    req = 2'b00;
    cyc();
    chk("t1_done0", done, 2'b00);
    chk("t1_idle", busy, 1'b0);

    // Length 0 means a full lap of 13 ticks
    req  = 2'b10;
    len1 = 4'd0;
    cyc();
    chk("t2_gnt", gnt, 2'b10);
    chk("t2_qo0", qo, 4'd0);
    for (int i = 1; i <= 12; i++) begin
      cyc();
      chk($sformatf("t2_qo%0d", i), qo, i);
      chk("t2_nodone", done, 2'b00);
    end
    cyc();
    chk("t2_done", done, 2'b10);
    chk("t2_wrap", qo, 4'd0);
    req = 2'b00;
    cyc();
    chk("t2_idle", busy, 1'b0);

    // Both requesters held
`ifdef MOD13_SCHED_RR_EN
    exp_g[0] = 2'b01;
    exp_g[1] = 2'b10;
    exp_g[2] = 2'b01;
`else
    exp_g[0] = 2'b01;
    exp_g[1] = 2'b01;
    exp_g[2] = 2'b01;
`endif
    req  = 2'b11;
    len0 = 4'd2;
    len1 = 4'd2;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("t3_gnt%0d", k), gnt, exp_g[k]);
      cyc();
      cyc();
      chk($sformatf("t3_done%0d", k), done, exp_g[k]);
      cyc();
      chk($sformatf("t3_gap%0d", k), busy, 1'b0);
    end
    req = 2'b00;
    cyc();

    // Gated ticks; a len0 change mid-run must be ignored
    req  = 2'b01;
    len0 = 4'd5;
    tick = 1'b0;
    cyc();
    chk("t4_gnt", gnt, 2'b01);
    len0 = 4'd1;
    ecnt = 4'd0;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      t    = (i % 2 == 0);
      tick = t;
      cyc();
      if (t && ecnt == 4'd4) begin
        chk("t4_done", done, 2'b01);
        chk("t4_qow", qo, 4'd0);
        seen = 1'b1;
      end else begin
        if (t) ecnt = ecnt + 4'd1;
        chk($sformatf("t4_qo_i%0d", i), qo, ecnt);
        chk("t4_nodone", done, 2'b00);
      end
    end
    chk("t4_seen", seen, 1'b1);
    req  = 2'b00;
    tick = 1'b1;
    cyc();
    chk("t4_idle", busy, 1'b0);

    // Abandon at qo=2 with requester 1 pending
    req  = 2'b01;
    len0 = 4'd6;
    len1 = 4'd1;
    cyc();
    chk("t5_gnt", gnt, 2'b01);
    req = 2'b11;
    cyc();
    cyc();
    chk("t5_qo2", qo, 4'd2);
    req = 2'b10;
    cyc();
    chk("t5_gnt0", gnt, 2'b00);
    chk("t5_qo0", qo, 4'd0);
    chk("t5_nodone", done, 2'b00);
    cyc();
    chk("t5_gnt1", gnt, 2'b10);
    cyc();
    chk("t5_done1", done, 2'b10);
    req = 2'b00;
    cyc();
    chk("t5_idle", busy, 1'b0);

    // Asynchronous reset mid-run at qo=7
    req  = 2'b01;
    len0 = 4'd10;
    cyc();
    chk("t6_gnt", gnt, 2'b01);
    for (int i = 0; i < 7; i++) cyc();
    chk("t6_qo7", qo, 4'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rgnt", gnt, 2'b00);
    chk("t6_rbusy", busy, 1'b0);
    chk("t6_rqo", qo, 4'd0);
    chk("t6_rdone", done, 2'b00);
    cyc();
    chk("t6_hold_done", done, 2'b00);
    rst_n = 1'b1;
    req   = 2'b11;
    cyc();
    chk("t6_regnt", gnt, 2'b01);
    chk("t6_reqo", qo, 4'd0);
    req = 2'b00;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mod13_sched.md
MOD13_SCHED -- requirements
Module: mod13_sched

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port req, input, 2 bits: level request per requester, held until done or abandoned.
REQ-004 The block SHALL have the ports len0 and len1, input, 4 bits each: interval length in ticks requested by requester 0 and requester 1.
REQ-005 The block SHALL have the port tick, input, 1 bit: count enable for the shared mod-13 counter.
REQ-006 The block SHALL have the port gnt, output, 2 bits: one-hot grant, or 0 when no grant.
REQ-007 The block SHALL have the port done, output, 2 bits: one-cycle completion pulse to the granted requester.
REQ-008 The block SHALL have the port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 The block SHALL have the port qo, output, 4 bits: current shared counter value, 0..12.

Function
REQ-010 The block SHALL implement the FSM states IDLE, RUN and DONE, all registered.
REQ-011 In IDLE, on an edge with req != 0, the block SHALL select a winner w, latch Lw, clear cnt to 0, set gnt to one-hot(w) and move to RUN; gnt SHALL be visible the cycle after the request is sampled.
REQ-012 The effective length SHALL be 13 when the requested length is 0 or 13..15; otherwise it SHALL be the requested length (1..12).
REQ-013 In RUN, on an edge with tick=1 and cnt != Lw-1, cnt SHALL increment by 1; with tick=0, cnt SHALL hold.
REQ-014 In RUN, on an edge with tick=1 and cnt == Lw-1, the block SHALL set done[w]=1 and gnt=0, clear cnt to 0 and move to DONE.
REQ-015 cnt SHALL never exceed 12; the wrap from 12 to 0 SHALL occur only through completion (REQ-014).
REQ-016 The DONE state SHALL last exactly one cycle: done SHALL clear and the state SHALL return to IDLE unconditionally.
REQ-017 Requests SHALL NOT be sampled in DONE, so back-to-back grants are separated by at least one idle cycle.
REQ-018 In RUN, if req[w] deasserts (abandon), the block SHALL return to IDLE on that edge with cnt=0, gnt=0 and no done pulse.
REQ-019 Abandon SHALL take priority over completion on the same edge.
REQ-020 Changes to len0 or len1 during RUN SHALL be ignored; the latched Lw SHALL be used.
REQ-021 Requests from the non-granted requester during RUN SHALL be held pending and SHALL NOT affect the running interval.
REQ-022 qo SHALL equal cnt, and busy SHALL equal (state != IDLE).

Reset
REQ-023 When rst_n=0, the block SHALL immediately and asynchronously force state=IDLE, cnt=0, gnt=0, done=0, busy=0, qo=0 and last-winner pointer=1, regardless of clk.
REQ-024 Reset asserted mid-RUN SHALL discard the interval with no done pulse.
REQ-025 After rst_n rises, the first edge with req != 0 SHALL be arbitrated normally.

Configuration
REQ-026 With MOD13_SCHED_RR_EN defined, arbitration SHALL be round-robin: when both requests are set in IDLE, the requester that did not win last SHALL win, the last-winner pointer SHALL update on each grant, and after reset requester 0 SHALL win first.
REQ-027 Without MOD13_SCHED_RR_EN, arbitration SHALL be fixed priority with req[0] always winning, and the last-winner pointer logic SHALL be absent.
REQ-028 The port list SHALL be identical with and without the macro.

Verification
REQ-029 Reset then req=01, len0=3, tick=1 constantly -> gnt=01 one cycle later, qo steps 0,1,2, done=01 for one cycle, then busy=0.
REQ-030 req=10, len1=0, tick=1 -> qo counts 0..12, done=10 after the 13th tick, qo returns to 0.
REQ-031 Both req held, len0=len1=2, macro defined -> grants alternate 01,10,01; macro undefined -> every grant is 01.
REQ-032 len0=5 with tick toggling 1,0,1,0... -> qo holds on tick=0 cycles, done arrives after the 5th tick=1 edge.
REQ-033 Grant to req0, drop req[0] at qo=2 -> gnt=0 and qo=0 next cycle, no done; with req[1] pending, gnt=10 follows.
REQ-034 rst_n pulsed low at qo=7 asynchronously, between edges -> all outputs 0 immediately, no done pulse, and req0 wins the next grant.
